bus_arbiter: RTL and testbench

Central arbiter for one shared bus, either the Data bus or the Instruction bus; the top level instantiates it once per bus. It takes the per-core `*_Bus_RQ` lines from each core's arbitration submodule and returns a one-hot `*_Bus_GRANT`. A grant is held until the owner drops its request, with one isolation cycle between owners. Arbitration is round-robin, and optional preemption happens only at a completed bus transfer (`Bus_Ready`).

---
 rtl/bus_arbiter_pkg.sv | 21 ++
 rtl/bus_arbiter_if.sv | 32 +++
 rtl/bus_arbiter_picker.sv | 34 +++
 rtl/bus_arbiter.sv | 114 +++++++++++
 tb/tb_bus_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and width helpers for the round-robin bus arbiter.
// Imported by the interface, the picker and the arbiter top level.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_RELEASE = 2'd2
  } arbState_e;

  // Index width for n cores; a 2-core bus still needs one bit.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of the hold counter; kept at one bit when preemption is disabled.
  function automatic int unsigned holdWidth(input int unsigned maxHold);
    return (maxHold == 0) ? 1 : $clog2(maxHold + 1);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the per-core arbitration submodules and
// the central arbiter of one shared bus.
interface bus_arbiter_if #(
  parameter int unsigned N_CORES = 4
);
  import arb_pkg::*;

  localparam int unsigned ID_W = idxWidth(N_CORES);

  logic [N_CORES-1:0] Bus_RQ;
  logic               Bus_Ready;
  logic [N_CORES-1:0] Bus_GRANT;
  logic [ID_W-1:0]    Grant_Id;
  logic               Bus_Busy;

  modport master (
    output Bus_RQ,
    output Bus_Ready,
    input  Bus_GRANT,
    input  Grant_Id,
    input  Bus_Busy
  );

  modport slave (
    input  Bus_RQ,
    input  Bus_Ready,
    output Bus_GRANT,
    output Grant_Id,
    output Bus_Busy
  );

endinterface

// File: rtl/bus_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after
// (lastWinner+1) mod N_CORES.
module rr_priority_picker
  import arb_pkg::*;
#(
  parameter  int unsigned N_CORES = 4,
  localparam int unsigned IW      = idxWidth(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [IW-1:0]      lastWinner,
  output logic               found,
  output logic [IW-1:0]      winner
);

  // One extra bit so lastWinner+i never overflows before the single wrap.
  logic [IW:0] cand;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 1; i <= N_CORES; i++) begin
      cand = {1'b0, lastWinner} + (IW+1)'(i);
      if (cand >= (IW+1)'(N_CORES)) begin
        cand = cand - (IW+1)'(N_CORES);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Central arbiter for one shared bus: round-robin grant held until the
// owner drops, one all-zero isolation cycle between owners, optional preemption.
module bus_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned N_CORES  = 4,
  parameter  int unsigned MAX_HOLD = 0,
  localparam int unsigned IW       = idxWidth(N_CORES),
  localparam int unsigned HW       = holdWidth(MAX_HOLD)
) (
  input logic          clock,
  input logic          reset_n,
  bus_arbiter_if.slave bus
);

  localparam logic [IW-1:0] LAST_RESET = IW'(N_CORES - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MAX_HOLD);

  arbState_e          state, stateNext;
  logic [IW-1:0]      owner, ownerNext;
  logic [IW-1:0]      lastWinner, lastWinnerNext;
  logic [HW-1:0]      holdCnt, holdCntNext;
  logic [N_CORES-1:0] ownerMask;
  logic               preempt;
  logic               pickFound;
  logic [IW-1:0]      pickWinner;

  logic [N_CORES-1:0] grantQ;
  logic [IW-1:0]      idQ;
  logic               busyQ;

  rr_priority_picker #(
    .N_CORES (N_CORES)
  ) uPicker (
    .req        (bus.Bus_RQ),
    .lastWinner (lastWinner),
    .found      (pickFound),
    .winner     (pickWinner)
  );

  always_comb begin
    ownerMask        = '0;
    ownerMask[owner] = 1'b1;
  end

  always_comb begin
    preempt = 1'b0;
    if (MAX_HOLD != 0) begin
      preempt = (holdCnt == HOLD_MAX) && bus.Bus_Ready
                && (|(bus.Bus_RQ & ~ownerMask));
    end
  end

  always_comb begin
    stateNext      = state;
    ownerNext      = owner;
    lastWinnerNext = lastWinner;
    holdCntNext    = holdCnt;
    unique case (state)
      ARB_IDLE, ARB_RELEASE: begin
        if (pickFound) begin
          stateNext      = ARB_GRANTED;
          ownerNext      = pickWinner;
          lastWinnerNext = pickWinner;
          holdCntNext    = '0;
        end else begin
          stateNext = ARB_IDLE;
        end
      end
      ARB_GRANTED: begin
        // A drop coinciding with preemption is just a normal release.
        if (!bus.Bus_RQ[owner] || preempt) begin
          stateNext = ARB_RELEASE;
        end else if (holdCnt != HOLD_MAX) begin
          holdCntNext = holdCnt + 1'b1;
        end
      end
      default: stateNext = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      lastWinner <= LAST_RESET;
      holdCnt    <= '0;
    end else begin
      state      <= stateNext;
      owner      <= ownerNext;
      lastWinner <= lastWinnerNext;
      holdCnt    <= holdCntNext;
    end
  end

  // Outputs follow the state register, so a new owner's grant appears one
  // cycle after the RELEASE cycle has already driven all grants low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grantQ <= '0;
      idQ    <= '0;
      busyQ  <= 1'b0;
    end else begin
      grantQ <= (state == ARB_GRANTED) ? ownerMask : '0;
      idQ    <= owner;
      busyQ  <= (state == ARB_GRANTED);
    end
  end

  assign bus.Bus_GRANT = grantQ;
  assign bus.Grant_Id  = idQ;
  assign bus.Bus_Busy  = busyQ;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter: one instance with MAX_HOLD=4 and one
// with preemption disabled share the same stimulus.
module tb_bus_arbiter;
  import arb_pkg::*;

  localparam int unsigned N = 4;

  typedef struct {
    logic [3:0] rq;
    logic       rdy;
    logic [3:0] expA;
    logic [3:0] expB;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n;
  int unsigned nVec = 0;
  int unsigned nMis = 0;
  vec_t tbl1[$];
  vec_t tbl2[$];

  always #5 clock = ~clock;

  bus_arbiter_if #(.N_CORES(N)) busA ();
  bus_arbiter_if #(.N_CORES(N)) busB ();

  bus_arbiter #(.N_CORES(N), .MAX_HOLD(4)) dutA (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (busA)
  );

  bus_arbiter #(.N_CORES(N), .MAX_HOLD(0)) dutB (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (busB)
  );

  function automatic vec_t V(input logic [3:0] rq, input logic rdy,
                             input logic [3:0] a, input logic [3:0] b);
    vec_t r;
    r.rq = rq; r.rdy = rdy; r.expA = a; r.expB = b;
    return r;
  endfunction

  function automatic logic [1:0] idxOf(input logic [3:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic drive(input logic [3:0] rq, input logic rdy);
    busA.Bus_RQ = rq;  busB.Bus_RQ = rq;
    busA.Bus_Ready = rdy; busB.Bus_Ready = rdy;
  endtask

  task automatic checkDut(input string tag, input int k, input logic [3:0] g,
                          input logic b, input logic [1:0] id, input logic [3:0] exp);
    nVec++;
    if (g !== exp || b !== (|exp) || ((|exp) && id !== idxOf(exp))) begin
      nMis++;
      $display("FAIL %s[%0d]: grant=%b busy=%b id=%0d, want grant=%b busy=%b id=%0d",
               tag, k, g, b, id, exp, |exp, idxOf(exp));
    end
  endtask

  task automatic checkZero(input string tag);
    nVec++;
    if (busA.Bus_GRANT !== '0 || busA.Bus_Busy !== 1'b0 || busA.Grant_Id !== '0 ||
        busB.Bus_GRANT !== '0 || busB.Bus_Busy !== 1'b0 || busB.Grant_Id !== '0) begin
      nMis++;
      $display("FAIL %s: A grant=%b busy=%b id=%0d B grant=%b busy=%b id=%0d, want all 0",
               tag, busA.Bus_GRANT, busA.Bus_Busy, busA.Grant_Id,
               busB.Bus_GRANT, busB.Bus_Busy, busB.Grant_Id);
    end
  endtask

  task automatic invCheck(input string tag, input int c, input logic [3:0] g,
                          input logic b, input logic [1:0] id,
                          input logic [3:0] prevG, input logic [3:0] rqM1);
    nVec++;
    if ($countones(g) > 1 || b !== (|g) || (g & ~rqM1) != 4'b0000 ||
        (prevG != 4'b0000 && g != 4'b0000 && g != prevG) ||
        (g != 4'b0000 && id !== idxOf(g))) begin
      nMis++;
      $display("FAIL %s[%0d]: grant=%b busy=%b id=%0d prevGrant=%b rqPrevEdge=%b, want one-hot subset of rq, busy=|grant, gap on owner change",
               tag, c, g, b, id, prevG, rqM1);
    end
  endtask

  task automatic runTable(input string tag, input vec_t t[$]);
    foreach (t[k]) begin
      drive(t[k].rq, t[k].rdy);
      @(posedge clock); #1;
      checkDut({tag, "A"}, k, busA.Bus_GRANT, busA.Bus_Busy, busA.Grant_Id, t[k].expA);
      checkDut({tag, "B"}, k, busB.Bus_GRANT, busB.Bus_Busy, busB.Grant_Id, t[k].expB);
    end
  endtask

  initial begin
    logic [3:0] rq, rqM1, prevA, prevB, flip;
    logic       rdy;

    // Round-robin 0,1,2,3,0 with one zero cycle between owners, then idle.
    tbl1.push_back(V(4'b1111, 0, 4'b0000, 4'b0000));
    tbl1.push_back(V(4'b1111, 0, 4'b0001, 4'b0001));
    tbl1.push_back(V(4'b1111, 0, 4'b0001, 4'b0001));
    tbl1.push_back(V(4'b1110, 0, 4'b0001, 4'b0001));
    tbl1.push_back(V(4'b1111, 0, 4'b0000, 4'b0000));
    tbl1.push_back(V(4'b1111, 0, 4'b0010, 4'b0010));
    tbl1.push_back(V(4'b1111, 0, 4'b0010, 4'b0010));
    tbl1.push_back(V(4'b1101, 0, 4'b0010, 4'b0010));
    tbl1.push_back(V(4'b1111, 0, 4'b0000, 4'b0000));
    tbl1.push_back(V(4'b1111, 0, 4'b0100, 4'b0100));
    tbl1.push_back(V(4'b1111, 0, 4'b0100, 4'b0100));
    tbl1.push_back(V(4'b1011, 0, 4'b0100, 4'b0100));
    tbl1.push_back(V(4'b1111, 0, 4'b0000, 4'b0000));
    tbl1.push_back(V(4'b1111, 0, 4'b1000, 4'b1000));
    tbl1.push_back(V(4'b1111, 0, 4'b1000, 4'b1000));
    tbl1.push_back(V(4'b0111, 0, 4'b1000, 4'b1000));
    tbl1.push_back(V(4'b1111, 0, 4'b0000, 4'b0000));
    tbl1.push_back(V(4'b1111, 0, 4'b0001, 4'b0001));
    tbl1.push_back(V(4'b0000, 0, 4'b0001, 4'b0001));
    tbl1.push_back(V(4'b0000, 0, 4'b0000, 4'b0000));
    tbl1.push_back(V(4'b0000, 0, 4'b0000, 4'b0000));
    // Single requester: core 2 for five cycles.
    tbl1.push_back(V(4'b0100, 0, 4'b0000, 4'b0000));
    for (int i = 0; i < 4; i++) tbl1.push_back(V(4'b0100, 0, 4'b0100, 4'b0100));
    tbl1.push_back(V(4'b0000, 0, 4'b0100, 4'b0100));
    tbl1.push_back(V(4'b0000, 0, 4'b0000, 4'b0000));
    tbl1.push_back(V(4'b0000, 0, 4'b0000, 4'b0000));
    // Preemption: core 1 owns, core 3 waits; only A may preempt.
    tbl1.push_back(V(4'b0010, 0, 4'b0000, 4'b0000));
    tbl1.push_back(V(4'b1010, 0, 4'b0010, 4'b0010));
    tbl1.push_back(V(4'b1010, 1, 4'b0010, 4'b0010));
    tbl1.push_back(V(4'b1010, 1, 4'b0010, 4'b0010));
    tbl1.push_back(V(4'b1010, 0, 4'b0010, 4'b0010));
    tbl1.push_back(V(4'b1010, 0, 4'b0010, 4'b0010));
    tbl1.push_back(V(4'b1010, 1, 4'b0010, 4'b0010));
    tbl1.push_back(V(4'b1010, 0, 4'b0000, 4'b0010));
    tbl1.push_back(V(4'b1010, 0, 4'b1000, 4'b0010));
    tbl1.push_back(V(4'b1010, 0, 4'b1000, 4'b0010));
    tbl1.push_back(V(4'b0000, 0, 4'b1000, 4'b0010));
    tbl1.push_back(V(4'b0000, 0, 4'b0000, 4'b0000));
    tbl1.push_back(V(4'b0000, 0, 4'b0000, 4'b0000));
    // Core 1 owns again before the asynchronous reset.
    tbl1.push_back(V(4'b0010, 0, 4'b0000, 4'b0000));
    tbl1.push_back(V(4'b0010, 0, 4'b0010, 4'b0010));
    tbl1.push_back(V(4'b0010, 0, 4'b0010, 4'b0010));

    // After reset the pointer favours core 0 over core 2.
    tbl2.push_back(V(4'b0101, 0, 4'b0000, 4'b0000));
    tbl2.push_back(V(4'b0101, 0, 4'b0001, 4'b0001));
    tbl2.push_back(V(4'b0100, 0, 4'b0001, 4'b0001));
    tbl2.push_back(V(4'b0100, 0, 4'b0000, 4'b0000));
    tbl2.push_back(V(4'b0100, 0, 4'b0100, 4'b0100));
    tbl2.push_back(V(4'b0000, 0, 4'b0100, 4'b0100));
    tbl2.push_back(V(4'b0000, 0, 4'b0000, 4'b0000));

    reset_n = 1'b0;
    drive(4'b1111, 1'b0);
    @(posedge clock); #1;
    checkZero("reset_hold0");
    @(posedge clock); #1;
    checkZero("reset_hold1");
    reset_n = 1'b1;

    runTable("tbl1", tbl1);

    // Asynchronous reset mid-grant: grants must drop without a clock edge.
    #2 reset_n = 1'b0;
    #1 checkZero("async_reset_nocl");
    drive(4'b0101, 1'b0);
    @(posedge clock); #1;
    checkZero("async_reset_edge");
    reset_n = 1'b1;

    runTable("tbl2", tbl2);

    rq = 4'b0000; rqM1 = 4'b0000;
    prevA = busA.Bus_GRANT; prevB = busB.Bus_GRANT;
    for (int c = 0; c < 10000; c++) begin
      flip = 4'($urandom) & 4'($urandom);
      rq   = rq ^ flip;
      rdy  = 1'($urandom);
      drive(rq, rdy);
      @(posedge clock); #1;
      invCheck("invA", c, busA.Bus_GRANT, busA.Bus_Busy, busA.Grant_Id, prevA, rqM1);
      invCheck("invB", c, busB.Bus_GRANT, busB.Bus_Busy, busB.Grant_Id, prevB, rqM1);
      prevA = busA.Bus_GRANT;
      prevB = busB.Bus_GRANT;
      rqM1  = rq;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
